// File: rtl/speed_key_ctrl.sv
// Push-button front end for the variable clock divider: sync, debounce and step the divisor.
// Define AUTO_REPEAT_EN to make a held key repeat its step every REPEAT_CYCLES cycles.
module speed_key_ctrl #(
    parameter logic [27:0] DEFAULT_DIV     = 28'd50_000_000,
    parameter logic [27:0] MIN_DIV         = 28'd2_500_000,
    parameter logic [27:0] MAX_DIV         = 28'd200_000_000,
    parameter logic [27:0] STEP            = 28'd2_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_faster_n,
    input  logic        key_slower_n,
    output logic [27:0] dnew,
    output logic        dnew_upd,
    output logic        at_limit
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                          : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif
    localparam logic [28:0] DEC_THR   = {1'b0, MIN_DIV} + {1'b0, STEP};
    localparam logic        RST_LIMIT = (DEFAULT_DIV == MIN_DIV) || (DEFAULT_DIV == MAX_DIV);

    typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

    logic [1:0]       r_sync_f;
    logic [1:0]       r_sync_s;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [27:0]      r_dnew;
    logic             r_upd;
    logic             r_at_limit;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sel_nxt;
    logic             w_step;
    logic             w_fast;
    logic             w_slow;
    logic             w_sel_pr;
    logic             w_oth_pr;
    logic [28:0]      w_inc;
    logic [27:0]      w_step_val;

    // Synchronised pressed levels; r_sel = 1 means the faster key owns the FSM.
    assign w_fast   = ~r_sync_f[1];
    assign w_slow   = ~r_sync_s[1];
    assign w_sel_pr = r_sel ? w_fast : w_slow;
    assign w_oth_pr = r_sel ? w_slow : w_fast;

    always_comb begin
        w_inc      = {1'b0, r_dnew} + {1'b0, STEP};
        w_step_val = r_dnew;
        if (r_sel) begin
            w_step_val = ({1'b0, r_dnew} < DEC_THR) ? MIN_DIV : (r_dnew - STEP);
        end else begin
            w_step_val = (w_inc > {1'b0, MAX_DIV}) ? MAX_DIV : w_inc[27:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_step      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_fast ^ w_slow) begin
                    w_sel_nxt   = w_fast;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StDebounce;
                end
            end
            StDebounce: begin
                if (w_sel_pr && !w_oth_pr) begin
                    if (r_cnt == DEB_LAST) begin
                        w_step      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StHeld;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StHeld: begin
                if (!w_sel_pr) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRelease;
                end
`ifdef AUTO_REPEAT_EN
                else if (!w_oth_pr) begin
                    if (r_cnt == REP_LAST) begin
                        w_step    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
`endif
            end
            StRelease: begin
                // A re-press here is release bounce: back to HELD without a new step.
                if (w_sel_pr) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StHeld;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_f   <= 2'b11;
            r_sync_s   <= 2'b11;
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_sel      <= 1'b0;
            r_dnew     <= DEFAULT_DIV;
            r_upd      <= 1'b0;
            r_at_limit <= RST_LIMIT;
        end else begin
            r_sync_f <= {r_sync_f[0], key_faster_n};
            r_sync_s <= {r_sync_s[0], key_slower_n};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_upd    <= w_step && (w_step_val != r_dnew);
            if (w_step) begin
                r_dnew     <= w_step_val;
                r_at_limit <= (w_step_val == MIN_DIV) || (w_step_val == MAX_DIV);
            end
        end
    end

    assign dnew     = r_dnew;
    assign dnew_upd = r_upd;
    assign at_limit = r_at_limit;

endmodule

// File: tb/tb_speed_key_ctrl.sv
// Directed bench for speed_key_ctrl with small parameters; define AUTO_REPEAT_EN to cover repeat.
module tb_speed_key_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_faster_n = 1'b1;
    logic        key_slower_n = 1'b1;
    logic [27:0] dnew;
    logic        dnew_upd;
    logic        at_limit;

    int n_cmp = 0;
    int n_err = 0;
    int n_upd = 0;

    speed_key_ctrl #(
        .DEFAULT_DIV    (28'd1000),
        .MIN_DIV        (28'd100),
        .MAX_DIV        (28'd2000),
        .STEP           (28'd300),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_faster_n(key_faster_n),
        .key_slower_n(key_slower_n),
        .dnew        (dnew),
        .dnew_upd    (dnew_upd),
        .at_limit    (at_limit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dnew_upd === 1'b1) n_upd++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // e counts edges from edge 0 (first sample of the key low); key released after edge hold-1.
    task automatic press(input bit fast, input int hold, input logic [27:0] prev,
                         input logic [27:0] nxt, input bit exp_upd, input bit exp_lim,
                         input string tag);
        int base;
        base = n_upd;
        if (fast) key_faster_n = 1'b0;
        else      key_slower_n = 1'b0;
        for (int e = 0; e < hold + 14; e++) begin
            tick(1);
            if (e == 5) begin
                chk({tag, ":pre"}, dnew, prev);
                chk({tag, ":pre_upd"}, {27'd0, dnew_upd}, 28'd0);
            end
            if (e == 6) begin
                chk({tag, ":dnew"}, dnew, nxt);
                chk({tag, ":upd"}, {27'd0, dnew_upd}, {27'd0, exp_upd});
                chk({tag, ":lim"}, {27'd0, at_limit}, {27'd0, exp_lim});
            end
            if (e == 7) chk({tag, ":upd_off"}, {27'd0, dnew_upd}, 28'd0);
            if (e == hold - 1) begin
                key_faster_n = 1'b1;
                key_slower_n = 1'b1;
            end
        end
        chk({tag, ":final"}, dnew, nxt);
        chk({tag, ":npulse"}, 28'(n_upd - base), {27'd0, exp_upd});
    endtask

    initial begin
        int base;
        logic [27:0] exp_v;

        // 1: reset state and idle stability
        do_reset();
        chk("t1_rst_dnew", dnew, 28'd1000);
        chk("t1_rst_upd", {27'd0, dnew_upd}, 28'd0);
        chk("t1_rst_lim", {27'd0, at_limit}, 28'd0);
        base = n_upd;
        tick(20);
        chk("t1_idle_dnew", dnew, 28'd1000);
        chk("t1_idle_npulse", 28'(n_upd - base), 28'd0);

        // 2: one clean faster press
        press(1'b1, 12, 28'd1000, 28'd700, 1'b1, 1'b0, "t2");

        // 3: bouncing slower key is rejected, then a steady press is accepted
        do_reset();
        base = n_upd;
        for (int i = 0; i < 5; i++) begin
            key_slower_n = 1'b0;
            tick(3);
            key_slower_n = 1'b1;
            tick(1);
        end
        chk("t3_bounce_dnew", dnew, 28'd1000);
        chk("t3_bounce_npulse", 28'(n_upd - base), 28'd0);
        press(1'b0, 6, 28'd1000, 28'd1300, 1'b1, 1'b0, "t3_steady");

        // 4: faster presses saturate at MIN_DIV
        do_reset();
        press(1'b1, 12, 28'd1000, 28'd700, 1'b1, 1'b0, "t4_p1");
        press(1'b1, 12, 28'd700,  28'd400, 1'b1, 1'b0, "t4_p2");
        press(1'b1, 12, 28'd400,  28'd100, 1'b1, 1'b1, "t4_p3");
        press(1'b1, 12, 28'd100,  28'd100, 1'b0, 1'b1, "t4_p4");

        // 5: both keys together do nothing; slower presses saturate at MAX_DIV
        base = n_upd;
        key_faster_n = 1'b0;
        key_slower_n = 1'b0;
        tick(20);
        chk("t5_both_dnew", dnew, 28'd100);
        chk("t5_both_npulse", 28'(n_upd - base), 28'd0);
        key_faster_n = 1'b1;
        key_slower_n = 1'b1;
        tick(6);
        do_reset();
        press(1'b0, 12, 28'd1000, 28'd1300, 1'b1, 1'b0, "t5_p1");
        press(1'b0, 12, 28'd1300, 28'd1600, 1'b1, 1'b0, "t5_p2");
        press(1'b0, 12, 28'd1600, 28'd1900, 1'b1, 1'b0, "t5_p3");
        press(1'b0, 12, 28'd1900, 28'd2000, 1'b1, 1'b1, "t5_p4");

        // 6: reset during debounce with the key held, then the held key steps again
        key_slower_n = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(2);
        chk("t6_rst_dnew", dnew, 28'd1000);
        chk("t6_rst_upd", {27'd0, dnew_upd}, 28'd0);
        chk("t6_rst_lim", {27'd0, at_limit}, 28'd0);
        rst = 1'b0;
        press(1'b0, 12, 28'd1000, 28'd1300, 1'b1, 1'b0, "t6_post");

        do_reset();
`ifdef AUTO_REPEAT_EN
        base = n_upd;
        key_slower_n = 1'b0;
        for (int e = 0; e < 50; e++) begin
            tick(1);
            exp_v = (e < 6) ? 28'd1000 : (e < 14) ? 28'd1300 : (e < 22) ? 28'd1600 :
                    (e < 30) ? 28'd1900 : 28'd2000;
            chk("t6_rep_dnew", dnew, exp_v);
            chk("t6_rep_upd", {27'd0, dnew_upd},
                (e == 6 || e == 14 || e == 22 || e == 30) ? 28'd1 : 28'd0);
            chk("t6_rep_lim", {27'd0, at_limit}, (e >= 30) ? 28'd1 : 28'd0);
            if (e == 39) key_slower_n = 1'b1;
        end
        chk("t6_rep_npulse", 28'(n_upd - base), 28'd4);
`else
        exp_v = 28'd1300;
        press(1'b0, 40, 28'd1000, exp_v, 1'b1, 1'b0, "t6_hold");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
